// File: rtl/fft_dma_sched_pkg.sv
// Shared definitions for the FFT frame scheduler.
//   sched_state_t  : job-level FSM encoding (S_IDLE / S_RUN / S_DONE)
//   chan_state_t   : per-DMA-channel occupancy (CH_IDLE / CH_BUSY)
//   DMA_BEAT_BYTES : DMA bus beat size; frame sizes are whole beats.
package fft_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } chan_state_t;

  localparam int unsigned DMA_BEAT_BYTES = 8;

endpackage

// File: rtl/fft_dma_sched_dma_chan_seq.sv
// One DMA channel sequencer (used for both RDMA and WDMA).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : latch a new descriptor and clear the counters
//   base, stride, xfer    : first address, per-frame increment, bytes per frame
//   start_ok              : scheduler allows a start this cycle
//   dma_done              : frame-complete pulse from the engine
//   dma_start             : one-cycle start pulse to the engine
//   done_evt              : a done that was accepted (channel was busy)
//   addr, xfer_byte       : registered frame parameters for the engine
//   issued, done_cnt      : frames started / frames completed in this job
module dma_chan_seq
  import fft_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] xfer,
  input  logic                  start_ok,
  input  logic                  dma_done,
  output logic                  dma_start,
  output logic                  done_evt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] xfer_byte,
  output logic [FCNT_WIDTH-1:0] issued,
  output logic [FCNT_WIDTH-1:0] done_cnt
);

  chan_state_t           st;
  logic [ADDR_WIDTH-1:0] acc;       // address of the next frame to be issued
  logic [ADDR_WIDTH-1:0] stride_q;

  assign dma_start = start_ok && (st == CH_IDLE);
  // A done while idle (stray or left over from before reset) is dropped.
  assign done_evt  = dma_done && (st == CH_BUSY);

  // addr shows the in-flight frame until its done, then the next frame's
  // address, so it is already valid in the cycle of the following start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= CH_IDLE;
      acc       <= '0;
      stride_q  <= '0;
      addr      <= '0;
      xfer_byte <= '0;
      issued    <= '0;
      done_cnt  <= '0;
    end else if (load) begin
      st        <= CH_IDLE;
      acc       <= base;
      stride_q  <= stride;
      addr      <= base;
      xfer_byte <= xfer;
      issued    <= '0;
      done_cnt  <= '0;
    end else if (dma_start) begin
      st     <= CH_BUSY;
      acc    <= acc + stride_q;
      issued <= issued + FCNT_WIDTH'(1);
    end else if (done_evt) begin
      st       <= CH_IDLE;
      addr     <= acc;
      done_cnt <= done_cnt + FCNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fft_dma_sched.sv
// Frame scheduler between the control register file and the RDMA/WDMA
// engines. Latches one job descriptor on an ap_start rising edge, then starts
// RDMA and WDMA once per frame, keeping RDMA at most MAX_AHEAD frames ahead
// of completed WDMA frames.
// Ports:
//   ap_clk, ap_rst_n                 : clock, asynchronous active-low reset
//   ap_start/ap_done/ap_idle/ap_ready: host handshake
//   num_frames, frame_byte           : job size
//   src_base/src_stride              : read addressing
//   dst_base/dst_stride              : write addressing
//   rdma_* / wdma_*                  : engine start, parameters and done
//   busy_frames                      : frames read-issued but not yet written
module fft_dma_sched
  import fft_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FCNT_WIDTH = 16,
  parameter int MAX_AHEAD  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [FCNT_WIDTH-1:0] num_frames,
  input  logic [ADDR_WIDTH-1:0] frame_byte,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] src_stride,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] dst_stride,
  output logic                  rdma_ap_start,
  output logic [ADDR_WIDTH-1:0] rdma_transfer_byte,
  output logic [ADDR_WIDTH-1:0] rdma_read_base_addr,
  input  logic                  rdma_ap_done,
  output logic                  wdma_ap_start,
  output logic [ADDR_WIDTH-1:0] wdma_transfer_byte,
  output logic [ADDR_WIDTH-1:0] wdma_write_base_addr,
  input  logic                  wdma_ap_done,
  output logic [FCNT_WIDTH-1:0] busy_frames
);

  sched_state_t          state, state_nxt;
  logic                  ap_start_q;
  logic                  load;
  logic [FCNT_WIDTH-1:0] num_q;
  logic [FCNT_WIDTH-1:0] rd_issued, rd_done, wr_issued, wr_done, wr_done_nxt;
  logic [FCNT_WIDTH-1:0] ahead;
  logic                  rd_ok, wr_ok, rd_done_evt, wr_done_evt;
  logic                  unused_rd;

  assign load  = (state == S_IDLE) && ap_start && !ap_start_q;
  assign ahead = rd_issued - wr_done;
  assign rd_ok = (state == S_RUN) && (rd_issued < num_q) &&
                 (ahead < FCNT_WIDTH'(MAX_AHEAD));
  assign wr_ok = (state == S_RUN) && (wr_issued < rd_issued);
  // Completion check sees this cycle's accepted WDMA done.
  assign wr_done_nxt = wr_done + FCNT_WIDTH'(wr_done_evt);

  // Read-side completion is implied by the write side; not needed here.
  assign unused_rd = ^{rd_done, rd_done_evt};

  assign ap_idle     = (state == S_IDLE);
  assign ap_done     = (state == S_DONE);
  assign busy_frames = ahead;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      ap_start_q <= 1'b0;
      ap_ready   <= 1'b0;
      num_q      <= '0;
    end else begin
      state      <= state_nxt;
      ap_start_q <= ap_start;
      ap_ready   <= load;
      if (load) num_q <= num_frames;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_RUN;
      S_RUN:   if (wr_done_nxt == num_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  dma_chan_seq #(.ADDR_WIDTH(ADDR_WIDTH), .FCNT_WIDTH(FCNT_WIDTH)) u_rd (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (load),
    .base      (src_base),
    .stride    (src_stride),
    .xfer      (frame_byte),
    .start_ok  (rd_ok),
    .dma_done  (rdma_ap_done),
    .dma_start (rdma_ap_start),
    .done_evt  (rd_done_evt),
    .addr      (rdma_read_base_addr),
    .xfer_byte (rdma_transfer_byte),
    .issued    (rd_issued),
    .done_cnt  (rd_done)
  );

  dma_chan_seq #(.ADDR_WIDTH(ADDR_WIDTH), .FCNT_WIDTH(FCNT_WIDTH)) u_wr (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (load),
    .base      (dst_base),
    .stride    (dst_stride),
    .xfer      (frame_byte),
    .start_ok  (wr_ok),
    .dma_done  (wdma_ap_done),
    .dma_start (wdma_ap_start),
    .done_evt  (wr_done_evt),
    .addr      (wdma_write_base_addr),
    .xfer_byte (wdma_transfer_byte),
    .issued    (wr_issued),
    .done_cnt  (wr_done)
  );

endmodule
